// File: rtl/moore_det_pkg.sv
// rtl/moore_det_pkg.sv - shared state encoding and sequence constants for moore_det_sched
package moore_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Flush pattern, LSB first: 1,1,0,0 walks the detector from any state to S0
    localparam logic [3:0] FLUSH_SEQ = 4'b0011;
    localparam int         FLUSH_LEN = 4;
    localparam int         DRAIN_LEN = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with last-grant memory
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       valid_o,
    output logic       id_o
);

    logic last_q;
    logic last_d;

    // Pick the requester that did not win last time when both ask
    always_comb begin
        valid_o = |req_i;
        id_o    = (req_i == 2'b11) ? ~last_q : req_i[1];
        last_d  = (en_i && valid_o) ? id_o : last_q;
    end

    // Last-grant register; reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/moore_det_sched.sv
// rtl/moore_det_sched.sv - shares one Moore sequence detector between two word requesters
module moore_det_sched
    import moore_det_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             ClkM_i,
    input  logic             RstM_i,
    input  logic             Req0_i,
    input  logic [WIDTH-1:0] Data0_i,
    input  logic             Req1_i,
    input  logic [WIDTH-1:0] Data1_i,
    output logic             Done0_o,
    output logic             Done1_o,
    output logic [CNTW-1:0]  Count_o,
    output logic             Busy_o,
    output logic             DetA_o,
    input  logic             DetZ_i
);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  phase_q, phase_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             gid_q, gid_d;
    logic             deta_q, deta_d;
    logic             v0_q, v0_d;
    logic             v1_q, v2_q;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             arb_en, arb_valid, arb_id;
    logic             grant;

    assign arb_en = (state_q == ST_IDLE);
    assign grant  = arb_en && arb_valid;

    rr_arb2 u_arb (
        .clk_i   (ClkM_i),
        .rst_i   (RstM_i),
        .req_i   ({Req1_i, Req0_i}),
        .en_i    (arb_en),
        .valid_o (arb_valid),
        .id_o    (arb_id)
    );

    // State and datapath registers; reset abandons any job in flight
    always_ff @(posedge ClkM_i or posedge RstM_i) begin
        if (RstM_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            shreg_q <= '0;
            gid_q   <= 1'b0;
            deta_q  <= 1'b0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            gid_q   <= gid_d;
            deta_q  <= deta_d;
            v0_q    <= v0_d;
            v1_q    <= v0_q;
            v2_q    <= v1_q;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // Sequencer: grant, flush, shift the word out, drain, report
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        gid_d   = gid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_FLUSH;
                    phase_d = '0;
                    gid_d   = arb_id;
                    shreg_d = arb_id ? Data1_i : Data0_i;
                end
            end
            ST_FLUSH: begin
                if (phase_q == CNTW'(FLUSH_LEN - 1)) begin
                    state_d = ST_SHIFT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNTW'(1);
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q >> 1;
                if (phase_q == CNTW'(WIDTH - 1)) begin
                    state_d = ST_DRAIN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNTW'(1);
                end
            end
            ST_DRAIN: begin
                // One cycle beyond DRAIN_LEN: DetA trails the state by a register, so
                // the last data bit's Z is sampled on the edge that enters DONE.
                if (phase_q == CNTW'(DRAIN_LEN)) begin
                    state_d = ST_DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNTW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Detector drive, data-valid pipe and Z counter
    always_comb begin
        deta_d  = 1'b0;
        v0_d    = 1'b0;
        cnt_d   = cnt_q;
        count_d = count_q;
        if (state_q == ST_FLUSH) begin
            deta_d = FLUSH_SEQ[phase_q[1:0]];
        end else if (state_q == ST_SHIFT) begin
            deta_d = shreg_q[0];
            v0_d   = 1'b1;
        end
        if (grant) begin
            cnt_d = '0;
        end else if (v2_q && DetZ_i) begin
            cnt_d = cnt_q + CNTW'(1);
        end
        if (state_q == ST_DRAIN && state_d == ST_DONE) begin
            count_d = cnt_d;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        Busy_o  = (state_q != ST_IDLE);
        Done0_o = (state_q == ST_DONE) && !gid_q;
        Done1_o = (state_q == ST_DONE) && gid_q;
        DetA_o  = deta_q;
        Count_o = count_q;
    end

endmodule

// File: tb/tb_moore_det_sched.sv
// tb/tb_moore_det_sched.sv - directed bench for moore_det_sched with a detector model
module tb_moore_det_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       done0, done1, busy, deta;
    logic [3:0] count;

    // Detector model: no reset, Z registered one edge behind its state
    logic [1:0] det_s = 2'd1;
    logic       det_z = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (det_s)
            2'd0:    det_s <= deta ? 2'd2 : 2'd0;
            2'd1:    det_s <= deta ? 2'd2 : 2'd0;
            2'd2:    det_s <= deta ? 2'd3 : 2'd2;
            default: det_s <= deta ? 2'd3 : 2'd1;
        endcase
        det_z <= (det_s == 2'd0) || (det_s == 2'd3);
    end

    moore_det_sched #(.WIDTH(8), .CNTW(4)) dut (
        .ClkM_i  (clk),
        .RstM_i  (rst),
        .Req0_i  (req0),
        .Data0_i (data0),
        .Req1_i  (req1),
        .Data1_i (data1),
        .Done0_o (done0),
        .Done1_o (done1),
        .Count_o (count),
        .Busy_o  (busy),
        .DetA_o  (deta),
        .DetZ_i  (det_z)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requests must already be set; the next posedge is the grant edge
    task automatic run_job(input string tag, input logic exp_gid, input logic [7:0] exp_word,
                           input logic [3:0] exp_cnt, input logic [3:0] prev_cnt);
        logic [3:0] fl;
        logic       exp_a;
        fl = 4'b0011;
        @(posedge clk); #1;
        check_eq($sformatf("%s.busy_grant", tag), busy, 1);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (i <= 12) begin
                exp_a = (i <= 4) ? fl[i-1] : exp_word[i-5];
                check_eq($sformatf("%s.deta_%0d", tag, i), deta, exp_a);
            end
            if (i == 5)  check_eq($sformatf("%s.count_held", tag), count, prev_cnt);
            if (i == 14) check_eq($sformatf("%s.no_early_done", tag), {done1, done0}, 2'b00);
        end
        check_eq($sformatf("%s.done", tag), {done1, done0}, exp_gid ? 2'b10 : 2'b01);
        check_eq($sformatf("%s.count", tag), count, exp_cnt);
        check_eq($sformatf("%s.busy_done", tag), busy, 1);
        @(posedge clk); #1;
        check_eq($sformatf("%s.idle_after", tag), {busy, done1, done0}, 3'b000);
        check_eq($sformatf("%s.count_kept", tag), count, exp_cnt);
    endtask

    // Start a requester-0 job and kill it with reset part-way through SHIFT
    task automatic abort_job(input string tag, input logic [7:0] word);
        req0 = 1'b1;
        data0 = word;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #3;
        check_eq($sformatf("%s.busy_pre", tag), busy, 1);
        rst = 1'b1;
        #1;
        check_eq($sformatf("%s.rst_outs", tag), {busy, done1, done0, deta}, 4'b0000);
        check_eq($sformatf("%s.rst_count", tag), count, 0);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq($sformatf("%s.no_done", tag), {busy, done1, done0}, 3'b000);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.outs", {busy, done1, done0, deta}, 4'b0000);
        check_eq("reset.count", count, 0);
        rst = 1'b0;

        req0 = 1'b1; data0 = 8'h00;
        run_job("t1_zero", 1'b0, 8'h00, 4'd8, 4'd0);
        req0 = 1'b0;

        req1 = 1'b1; data1 = 8'hFF;
        run_job("t2_ones", 1'b1, 8'hFF, 4'd7, 4'd8);
        req1 = 1'b0;

        req0 = 1'b1; data0 = 8'h55;
        run_job("t3_55", 1'b0, 8'h55, 4'd2, 4'd7);
        req0 = 1'b0;

        abort_job("t3_abort01", 8'h01);
        check_eq("t3.det_preload_s2", det_s, 2'd2);
        req0 = 1'b1; data0 = 8'h55;
        run_job("t3_55_flush", 1'b0, 8'h55, 4'd2, 4'd0);
        req0 = 1'b0;

        abort_job("t5_abort00", 8'h00);
        req0 = 1'b1; data0 = 8'h00;
        run_job("t5_after", 1'b0, 8'h00, 4'd8, 4'd0);
        req0 = 1'b0;

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; data0 = 8'h00;
        req1 = 1'b1; data1 = 8'hFF;
        run_job("t4_job1", 1'b0, 8'h00, 4'd8, 4'd0);
        run_job("t4_job2", 1'b1, 8'hFF, 4'd7, 4'd8);
        run_job("t4_job3", 1'b0, 8'h00, 4'd8, 4'd7);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        check_eq("t4.stays_idle", busy, 0);

        req0 = 1'b1; data0 = 8'h55;
        fork
            run_job("t6_drop", 1'b0, 8'h55, 4'd2, 4'd8);
            begin
                repeat (3) @(posedge clk);
                #2;
                req0 = 1'b0;
                data0 = 8'h00;
            end
        join
        @(posedge clk); #1;
        check_eq("t6.no_regrant", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
